btn_scan_sched: RTL and testbench

BTN_SCAN_SCHED -- requirements
Module: btn_scan_sched

---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_evt_fifo.sv | 55 +++++
 rtl/btn_scan_sched.sv | 165 ++++++++++++++++
 tb/tb_btn_scan_sched.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default parameters for the button scan scheduler.
package btn_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   localparam int unsigned N_BTN_DEF        = 4;
   localparam int unsigned TICK_DIV_DEF     = 48000;
   localparam int unsigned STABLE_TICKS_DEF = 20;
   localparam int unsigned FIFO_DEPTH_DEF   = 4;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event queue; a push into a full queue succeeds only if a pop happens in the same cycle.
module btn_evt_fifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 4
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CNT_W-1:0] r_cnt;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_cnt == CNT_W'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || i_pop);
   // Head is masked while empty so the outputs read zero out of reset.
   assign o_data    = o_empty ? '0 : r_mem[r_rd];

   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + 1'b1;
         if (w_pop_ok)  r_rd <= r_rd + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/btn_scan_sched.sv
// Debounces N_BTN buttons with a tick-driven round-robin scan and queues press/release events.
module btn_scan_sched
   import btn_pkg::*;
#(
   parameter int unsigned N_BTN        = N_BTN_DEF,
   parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
   parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
   parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
)(
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          CE,
   input  logic [N_BTN-1:0]              BTN_IN,
   output logic [N_BTN-1:0]              BTN_STATE,
   output logic                          EVT_VALID,
   input  logic                          EVT_READY,
   output logic [id_width(N_BTN)-1:0]    EVT_ID,
   output logic                          EVT_PRESS,
   output logic                          EVT_OVF
);

   localparam int unsigned ID_W = id_width(N_BTN);
   localparam int unsigned PW   = $clog2(TICK_DIV);
   localparam int unsigned CW   = $clog2(STABLE_TICKS);
   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_BTN - 1);

   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [PW-1:0]    r_presc;
   logic             w_tick;
   scan_state_t      r_state;
   scan_state_t      w_state_nx;
   logic [ID_W-1:0]  r_idx;
   logic [ID_W-1:0]  w_idx_nx;
   logic             r_pend;
   logic             w_pend_nx;
   logic [CW-1:0]    r_cnt [N_BTN];
   logic [N_BTN-1:0] r_btn_state;
   logic             r_ovf;

   logic             w_proc;
   logic             w_lvl;
   logic [CW-1:0]    w_cnt_cur;
   logic             w_agree;
   logic             w_accept;
   logic [ID_W:0]    w_evt;
   logic [ID_W:0]    w_head;
   logic             w_full;
   logic             w_empty;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= BTN_IN;
         r_sync2 <= r_sync1;
      end
   end

   assign w_tick = CE && (r_presc == PW'(TICK_DIV - 1));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_presc <= '0;
      end else if (CE) begin
         r_presc <= (r_presc == PW'(TICK_DIV - 1)) ? '0 : r_presc + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_pend  <= w_pend_nx;
      end
   end

   // A tick landing on the last index restarts the scan directly, same as a pending one.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_pend_nx  = r_pend;
      if (CE) begin
         case (r_state)
            IDLE: begin
               if (w_tick) begin
                  w_state_nx = SCAN;
                  w_idx_nx   = '0;
               end
            end
            SCAN: begin
               if (r_idx == LAST_IDX) begin
                  w_idx_nx   = '0;
                  w_pend_nx  = 1'b0;
                  w_state_nx = (r_pend || w_tick) ? SCAN : IDLE;
               end else begin
                  w_idx_nx = r_idx + 1'b1;
                  if (w_tick) w_pend_nx = 1'b1;
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_idx_nx   = '0;
               w_pend_nx  = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_proc    = CE && (r_state == SCAN);
      w_lvl     = r_sync2[r_idx];
      w_cnt_cur = r_cnt[r_idx];
      w_agree   = (w_lvl == r_btn_state[r_idx]);
      w_accept  = w_proc && !w_agree && (w_cnt_cur == CW'(STABLE_TICKS - 1));
      w_evt     = {r_idx, w_lvl};
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int unsigned i = 0; i < N_BTN; i++) begin
            r_cnt[i] <= '0;
         end
         r_btn_state <= '0;
      end else if (w_proc) begin
         if (w_agree || w_accept) r_cnt[r_idx] <= '0;
         else                     r_cnt[r_idx] <= w_cnt_cur + 1'b1;
         if (w_accept) r_btn_state[r_idx] <= w_lvl;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_ovf <= 1'b0;
      end else if (w_accept && w_full && !EVT_READY) begin
         r_ovf <= 1'b1;
      end
   end

   btn_evt_fifo #(
      .WIDTH (ID_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_push  (w_accept),
      .i_data  (w_evt),
      .i_pop   (EVT_READY),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign BTN_STATE = r_btn_state;
   assign EVT_VALID = !w_empty;
   assign EVT_ID    = w_head[ID_W:1];
   assign EVT_PRESS = w_head[0];
   assign EVT_OVF   = r_ovf;

endmodule

// File: tb/tb_btn_scan_sched.sv
// Directed bench for btn_scan_sched with a fast tick (TICK_DIV=4) and 3-scan debounce.
module tb_btn_scan_sched;
   import btn_pkg::*;

   logic       clk;
   logic       rst;
   logic       ce;
   logic [3:0] btn;
   logic [3:0] st;
   logic       valid;
   logic       rdy;
   logic [1:0] id;
   logic       press;
   logic       ovf;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   logic        bad;
   logic        seen;
   logic        found;

   btn_scan_sched #(
      .N_BTN        (4),
      .TICK_DIV     (4),
      .STABLE_TICKS (3),
      .FIFO_DEPTH   (4)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .CE        (ce),
      .BTN_IN    (btn),
      .BTN_STATE (st),
      .EVT_VALID (valid),
      .EVT_READY (rdy),
      .EVT_ID    (id),
      .EVT_PRESS (press),
      .EVT_OVF   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_valid(input int unsigned budget, input string tag);
      int unsigned k = 0;
      while (!valid && k < budget) begin
         tick();
         k++;
      end
      chk(tag, {31'b0, valid}, 32'd1);
   endtask

   task automatic wait_st(input int unsigned idx, input logic val, input string tag);
      int unsigned k = 0;
      while (st[idx] !== val && k < 18) begin
         tick();
         k++;
      end
      chk(tag, {31'b0, st[idx]}, {31'b0, val});
   endtask

   task automatic pop_chk(input string tag, input logic [1:0] eid, input logic ep);
      chk({tag, "_v"},  {31'b0, valid}, 32'd1);
      chk({tag, "_id"}, {30'b0, id},    {30'b0, eid});
      chk({tag, "_p"},  {31'b0, press}, {31'b0, ep});
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      ce  = 1'b1;
      btn = 4'b0000;
      rdy = 1'b0;
      @(negedge clk);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("rst_state", {28'b0, st},    32'h0);
      chk("rst_valid", {31'b0, valid}, 32'h0);
      chk("rst_id",    {30'b0, id},    32'h0);
      chk("rst_press", {31'b0, press}, 32'h0);
      chk("rst_ovf",   {31'b0, ovf},   32'h0);
      repeat (30) tick();
      chk("idle_novalid", {31'b0, valid}, 32'h0);

      // single press on button 2
      btn = 4'b0100;
      wait_valid(18, "press2_found");
      chk("press2_id",    {30'b0, id},    32'd2);
      chk("press2_press", {31'b0, press}, 32'd1);
      chk("press2_state", {28'b0, st},    32'h4);
      repeat (3) tick();
      chk("hold_id",    {30'b0, id},    32'd2);
      chk("hold_valid", {31'b0, valid}, 32'd1);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      repeat (40) tick();
      chk("no_more_evt", {31'b0, valid}, 32'h0);
      chk("press2_keep", {28'b0, st},    32'h4);

      // bounce on button 0 faster than the debounce window
      bad  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (i % 3 == 0) btn[0] = ~btn[0];
         tick();
         if (st[0]) bad = 1'b1;
         if (valid) seen = 1'b1;
      end
      btn[0] = 1'b0;
      repeat (20) begin
         tick();
         if (st[0]) bad = 1'b1;
         if (valid) seen = 1'b1;
      end
      chk("bounce_state", {31'b0, bad},  32'h0);
      chk("bounce_evt",   {31'b0, seen}, 32'h0);

      btn[2] = 1'b0;
      wait_valid(18, "rel2_found");
      pop_chk("rel2", 2'd2, 1'b0);

      // fill the queue with no consumer, then overflow it
      btn[0] = 1'b1; wait_st(0, 1'b1, "fill_p0");
      btn[1] = 1'b1; wait_st(1, 1'b1, "fill_p1");
      btn[2] = 1'b1; wait_st(2, 1'b1, "fill_p2");
      btn[0] = 1'b0; wait_st(0, 1'b0, "fill_r0");
      tick();
      chk("full_valid", {31'b0, valid}, 32'd1);
      chk("full_noovf", {31'b0, ovf},   32'h0);
      btn[3] = 1'b1; wait_st(3, 1'b1, "drop_state");
      chk("drop_ovf", {31'b0, ovf}, 32'd1);
      pop_chk("ovf_pop0", 2'd0, 1'b1);
      pop_chk("ovf_pop1", 2'd1, 1'b1);
      pop_chk("ovf_pop2", 2'd2, 1'b1);
      pop_chk("ovf_pop3", 2'd0, 1'b0);
      chk("ovf_empty",  {31'b0, valid}, 32'h0);
      chk("ovf_sticky", {31'b0, ovf},   32'd1);

      btn = 4'b0000;
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("rst2_ovf",   {31'b0, ovf},   32'h0);
      chk("rst2_state", {28'b0, st},    32'h0);
      chk("rst2_valid", {31'b0, valid}, 32'h0);

      // full queue: push and pop land on the same edge
      btn[0] = 1'b1; wait_st(0, 1'b1, "pp_p0");
      btn[1] = 1'b1; wait_st(1, 1'b1, "pp_p1");
      btn[2] = 1'b1; wait_st(2, 1'b1, "pp_p2");
      btn[3] = 1'b1; wait_st(3, 1'b1, "pp_p3");
      tick();
      btn[0] = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (dut.r_state == SCAN && dut.r_idx == 2'd0 && dut.r_cnt[0] == 2'd2) found = 1'b1;
         else tick();
      end
      chk("pp_align", {31'b0, found}, 32'd1);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      chk("pp_noovf", {31'b0, ovf},   32'h0);
      chk("pp_state", {28'b0, st},    32'he);
      pop_chk("pp_pop0", 2'd1, 1'b1);
      pop_chk("pp_pop1", 2'd2, 1'b1);
      pop_chk("pp_pop2", 2'd3, 1'b1);
      pop_chk("pp_pop3", 2'd0, 1'b0);
      chk("pp_empty", {31'b0, valid}, 32'h0);

      // scan frozen while CE is low
      btn[1] = 1'b0; wait_st(1, 1'b0, "ce_prep");
      pop_chk("ce_prep_pop", 2'd1, 1'b0);
      ce     = 1'b0;
      btn[1] = 1'b1;
      seen   = 1'b0;
      repeat (20) begin
         tick();
         if (valid) seen = 1'b1;
      end
      chk("ce_noevt", {31'b0, seen}, 32'h0);
      chk("ce_state", {28'b0, st},   32'hc);
      ce = 1'b1;
      wait_valid(16, "ce_found");
      pop_chk("ce_evt", 2'd1, 1'b1);

      // reset in the middle of a scan
      btn[0] = 1'b1;
      repeat (6) tick();
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         if (dut.r_state == SCAN && dut.r_idx == 2'd2) found = 1'b1;
         else tick();
      end
      chk("mid_align", {31'b0, found}, 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_idle",  {31'b0, dut.r_state == IDLE}, 32'd1);
      chk("mid_cnt0",  {30'b0, dut.r_cnt[0]}, 32'h0);
      chk("mid_cnt1",  {30'b0, dut.r_cnt[1]}, 32'h0);
      chk("mid_cnt2",  {30'b0, dut.r_cnt[2]}, 32'h0);
      chk("mid_cnt3",  {30'b0, dut.r_cnt[3]}, 32'h0);
      chk("mid_valid", {31'b0, valid}, 32'h0);
      chk("mid_state", {28'b0, st},    32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
